// File: rtl/instr_loader.sv
// Boot-time instruction loader: receives a length-prefixed, XOR-checksummed byte
// stream and writes it into instruction memory one 32-bit word at a time.
module instr_loader #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state_o
);

  // Handshake: a byte moves only on a rising edge where byte_valid && byte_ready;
  // byte_ready depends on state alone, never on byte_valid.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_CHECK = 3'd4
  } state_e;

  localparam logic [63:0] MEM_BYTES = 64'(MEM_SIZE);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] pack_q, pack_d;
  logic [7:0]  chk_q, chk_d;
  logic        wr_en_q, wr_en_d;
  logic [63:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        hold_q;

  logic        xfer;
  logic [15:0] n_full;
  logic [63:0] n_bytes;
  logic        too_big;

  assign byte_ready  = (state_q != S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign xfer        = byte_valid && byte_ready;
  assign n_full      = {byte_in, len_q[7:0]};
  assign n_bytes     = {46'd0, n_full, 2'b00};
  // Exactly filling memory is fine: the last word ends at MEM_SIZE-1.
  assign too_big     = (n_bytes > MEM_BYTES);

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign done        = done_q;
  assign error       = error_q;
  assign cpu_hold    = busy || hold_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    pack_d     = pack_q;
    chk_d      = chk_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LEN0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          chk_d      = 8'd0;
          len_d      = 16'd0;
          word_idx_d = 16'd0;
          byte_idx_d = 2'd0;
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = byte_in;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d[15:8] = byte_in;
          if (too_big) begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end else if (n_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          // Shift right so the first byte of a word ends up in bits 7:0.
          pack_d     = {byte_in, pack_q[31:8]};
          chk_d      = chk_q ^ byte_in;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_data_d  = pack_d;
            wr_addr_d  = {46'd0, word_idx_q, 2'b00};
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == len_q - 16'd1) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          state_d = S_IDLE;
          if (byte_in == chk_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      word_idx_q <= 16'd0;
      byte_idx_q <= 2'd0;
      pack_q     <= 32'd0;
      chk_q      <= 8'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 64'd0;
      wr_data_q  <= 32'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      pack_q     <= pack_d;
      chk_q      <= chk_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      // Keeps the CPU held for the cycle after the last write lands.
      hold_q     <= wr_en_q;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: stream vectors with hand-computed words and
// checksums, write scoreboard, reset/overflow/start-during-load cases.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic [95:0] exp_q[$];

  always #5 clk = ~clk;

  instr_loader #(.MEM_SIZE(1024)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .dbg_state_o(dbg_state_o)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and hold invariant, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("wr_en_unexpected", 96'(wr_en), 96'd0);
      else                   check("wr_word", {wr_addr, wr_data}, exp_q.pop_front());
    end
    if (busy === 1'b1) check("hold_while_busy", 96'(cpu_hold), 96'd1);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check("byte_ready_timeout", 96'(byte_ready), 96'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'($urandom_range(0, 255));
  endtask

  task automatic send_word(input logic [31:0] wd);
    for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 96'(byte_ready), 96'd0);
    check({tag, "_wr_en"},      96'(wr_en),      96'd0);
    check({tag, "_busy"},       96'(busy),       96'd0);
    check({tag, "_cpu_hold"},   96'(cpu_hold),   96'd0);
    check({tag, "_done"},       96'(done),       96'd0);
    check({tag, "_error"},      96'(error),      96'd0);
    check({tag, "_wr_addr"},    96'(wr_addr),    96'd0);
    check({tag, "_wr_data"},    96'(wr_data),    96'd0);
    check({tag, "_state"},      96'(dbg_state_o), 96'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int          wc;
    logic [7:0]  b;
    logic [7:0]  chk;
    logic [31:0] wd;

    reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Two words; XOR of the eight data bytes is 0x11.
    exp_q.push_back({64'h0, 32'h12345678});
    exp_q.push_back({64'h4, 32'h90ABCDEF});
    pulse_start();
    check("start_busy", 96'(busy), 96'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h12345678);
    send_word(32'h90ABCDEF);
    send_byte(8'h11);
    @(negedge clk);
    check("two_words_done",  96'(done),  96'd1);
    check("two_words_error", 96'(error), 96'd0);
    check("two_words_drain", 96'(exp_q.size()), 96'd0);
    check("two_words_wrcnt", 96'(wr_cnt), 96'd2);

    // Empty program: good then bad checksum.
    pulse_start();
    check("restart_clears_done", 96'(done), 96'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("empty_done",  96'(done),  96'd1);
    check("empty_error", 96'(error), 96'd0);
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    check("empty_bad_error", 96'(error), 96'd1);
    check("empty_bad_done",  96'(done),  96'd0);
    check("empty_no_writes", 96'(wr_cnt), 96'd2);

    // N=257 overflows 1024 bytes.
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    check("ovf_error",      96'(error),       96'd1);
    check("ovf_done",       96'(done),        96'd0);
    check("ovf_byte_ready", 96'(byte_ready),  96'd0);
    check("ovf_state",      96'(dbg_state_o), 96'd0);
    repeat (3) @(negedge clk);
    check("ovf_no_writes", 96'(wr_cnt), 96'd2);

    // One word with random gaps; checksum A1^B2^C3^D4 = 0x04 sent during wr_en.
    exp_q.push_back({64'h0, 32'hD4C3B2A1});
    wc = wr_cnt;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hA1); repeat ($urandom_range(1, 3)) @(negedge clk);
    send_byte(8'hB2); repeat ($urandom_range(1, 3)) @(negedge clk);
    send_byte(8'hC3); repeat ($urandom_range(1, 3)) @(negedge clk);
    send_byte(8'hD4);
    check("gap_wr_en_now", 96'(wr_en), 96'd1);
    send_byte(8'h04);
    check("gap_done",       96'(done),     96'd1);
    check("gap_busy_off",   96'(busy),     96'd0);
    check("gap_hold_extra", 96'(cpu_hold), 96'd1);
    @(negedge clk);
    check("gap_hold_drop",  96'(cpu_hold), 96'd0);
    check("gap_one_write",  96'(wr_cnt - wc), 96'd1);

    // Exactly full memory: 256 words, last at 0x3FC.
    chk = 8'h00;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(((4 * i + k) * 7) + 3);
        wd[8*k +: 8] = b;
        chk = chk ^ b;
      end
      exp_q.push_back({64'(4 * i), wd});
    end
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    for (int j = 0; j < 1024; j++) send_byte(8'((j * 7) + 3));
    send_byte(chk);
    check("full_done",  96'(done),  96'd1);
    check("full_error", 96'(error), 96'd0);
    check("full_drain", 96'(exp_q.size()), 96'd0);

    // Start pulsed during DATA; XOR of data bytes is 0x22.
    exp_q.push_back({64'h0, 32'hDEADBEEF});
    exp_q.push_back({64'h4, 32'h01234567});
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE);
    start = 1'b1;
    send_byte(8'hAD);
    start = 1'b0;
    send_byte(8'hDE);
    send_word(32'h01234567);
    send_byte(8'h22);
    check("midstart_done",  96'(done),  96'd1);
    check("midstart_error", 96'(error), 96'd0);
    check("midstart_drain", 96'(exp_q.size()), 96'd0);

    // byte_valid in IDLE without start.
    wc = wr_cnt;
    byte_valid = 1'b1; byte_in = 8'h5A;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    check("idle_state",      96'(dbg_state_o), 96'd0);
    check("idle_byte_ready", 96'(byte_ready),  96'd0);
    check("idle_done_held",  96'(done),        96'd1);
    check("idle_no_write",   96'(wr_cnt - wc), 96'd0);

    // Reset after two of three words.
    exp_q.push_back({64'h0, 32'h03020100});
    exp_q.push_back({64'h4, 32'h07060504});
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    send_word(32'h03020100);
    send_word(32'h07060504);
    send_byte(8'h08); send_byte(8'h09);
    check("rst_two_written", 96'(exp_q.size()), 96'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    wc = wr_cnt;
    byte_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      byte_in = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    byte_valid = 1'b0;
    check("postrst_state",      96'(dbg_state_o), 96'd0);
    check("postrst_byte_ready", 96'(byte_ready),  96'd0);
    check("postrst_no_write",   96'(wr_cnt - wc), 96'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
